// File: rtl/mfc_pkg.sv
// Shared types for the round-robin comparator scheduler.
package mfc_pkg;

  localparam int MFC_WIDTH = 16;
  localparam int MFC_D_W   = 4;
  localparam int MFC_ID_W  = 3;  // covers N_REQ up to 8

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RESPOND} state_t;

  typedef struct packed {
    logic [MFC_ID_W-1:0] id;
    logic                eq;
    logic                ae;
    logic                gt;
    logic [MFC_D_W-1:0]  d;
  } rsp_t;

endpackage

// File: rtl/mfc_rr_pick.sv
// Combinational round-robin finder: first asserted valid at or after rr_ptr.
module mfc_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  // Walk from farthest to nearest so the closest requester to rr_ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mfc_rr_scheduler.sv
// Shares one slow ripple comparator among N_REQ requesters: round-robin grant,
// hold operands for a settle time, capture flags, return on a valid/ready channel.
module mfc_rr_scheduler
  import mfc_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int WIDTH         = MFC_WIDTH,
  parameter int SETTLE_CYCLES = 40,
  parameter int ID_W          = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]       cmp_a,
  output logic [WIDTH-1:0]       cmp_b,
  input  logic                   cmp_eq,
  input  logic                   cmp_ae,
  input  logic                   cmp_gt,
  input  logic [MFC_D_W-1:0]     cmp_d,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_eq,
  output logic                   rsp_ae,
  output logic                   rsp_gt,
  output logic [MFC_D_W-1:0]     rsp_d,
  output logic                   busy
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic [CNT_W-1:0]  settle_cnt;
  rsp_t              rsp_q;
  logic [ID_W-1:0]   ptr_next;

  mfc_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign busy   = (state != IDLE);
  assign rsp_id = ID_W'(rsp_q.id);
  assign rsp_eq = rsp_q.eq;
  assign rsp_ae = rsp_q.ae;
  assign rsp_gt = rsp_q.gt;
  assign rsp_d  = rsp_q.d;

  // Operands are sampled only on the grant edge and held through RESPOND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      settle_cnt <= '0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      rsp_q      <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          cmp_a      <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
          cmp_b      <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
          rsp_q.id   <= MFC_ID_W'(grant_idx);
          settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
          rr_ptr     <= ptr_next;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= CAPTURE;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        CAPTURE: begin
          rsp_q.eq  <= cmp_eq;
          rsp_q.ae  <= cmp_ae;
          rsp_q.gt  <= cmp_gt;
          rsp_q.d   <= cmp_d;
          rsp_valid <= 1'b1;
          state     <= RESPOND;
        end
        RESPOND: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
